// File: rtl/tribus_arbiter_pkg.sv
// Shared definitions for the tristate bus arbiter.
// State encoding and the state type used by the controller.
package tribus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit
// at or above the pointer, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_k;

    // Scan from the far end down so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = IW'((int'(i_ptr) + i) % N);
            if (i_req[w_k]) begin
                o_found = 1'b1;
                o_idx   = w_k;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin burst arbiter driving one-hot tristate enables,
// with a one-cycle all-off turnaround between owners.
module tribus_arbiter
    import tribus_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAXBEATS = 4,
    parameter int IW       = 2,
    parameter int BW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    output logic [N-1:0]  drv_en,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [IW-1:0] owner,
    output logic [BW-1:0] beat
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic [N-1:0]  r_drv_en;
    logic [BW-1:0] r_beat;
    logic          r_busy;

    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_owner_nxt;
    logic [N-1:0]  w_en_nxt;
    logic [BW-1:0] w_beat_nxt;
    logic          w_found;
    logic [IW-1:0] w_idx;
    logic          w_end;
    logic [IW-1:0] w_ptr_inc;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_end = last[r_owner]
                 | (r_beat == BW'(MAXBEATS - 1))
                 | ~req[r_owner];

    assign w_ptr_inc = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, TURN: w_state_nxt = w_found ? DRIVE : IDLE;
            DRIVE:      w_state_nxt = w_end ? TURN : DRIVE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and the pointer.
    always_comb begin
        w_en_nxt    = '0;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE, TURN: begin
                if (w_found) begin
                    w_en_nxt    = N'(1) << w_idx;
                    w_owner_nxt = w_idx;
                    w_beat_nxt  = '0;
                end
            end
            DRIVE: begin
                if (w_end) begin
                    w_ptr_nxt = w_ptr_inc;
                end else begin
                    w_en_nxt   = r_drv_en;
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            default: w_en_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_drv_en <= '0;
            r_beat   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_drv_en <= w_en_nxt;
            r_beat   <= w_beat_nxt;
            r_busy   <= |w_en_nxt;
        end
    end

    assign drv_en = r_drv_en;
    assign gnt    = r_drv_en;
    assign busy   = r_busy;
    assign owner  = r_owner;
    assign beat   = r_beat;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: directed bursts with
// hand-computed expectations plus a randomized invariant run.
module tb_tribus_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic [3:0] drv_en;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic [2:0] beat;

    always #5 clk = ~clk;

    tribus_arbiter #(
        .N        (N),
        .MAXBEATS (MB),
        .IW       (2),
        .BW       (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .last   (last),
        .drv_en (drv_en),
        .gnt    (gnt),
        .busy   (busy),
        .owner  (owner),
        .beat   (beat)
    );

    typedef struct packed {
        logic       c;
        logic [3:0] en;
        logic [1:0] o;
        logic [2:0] b;
    } exp_t;

    exp_t       q[$];
    int         n_tot = 0;
    int         n_pass = 0;
    bit         started = 0;
    logic [3:0] prev_en = '0;
    int         wt[4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, a, e, $time);
    endtask

    task automatic step(input bit r, input logic [3:0] rq,
                        input logic [3:0] ls, input logic [3:0] en,
                        input int o, input int b, input bit c = 1'b1);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        last = ls;
        e.c  = c;
        e.en = en;
        e.o  = 2'(o);
        e.b  = 3'(b);
        q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, plus invariants.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                started = 1'b1;
                if (e.c) begin
                    chk("drv_en", 32'(drv_en), 32'(e.en));
                    chk("owner", 32'(owner), 32'(e.o));
                    chk("beat", 32'(beat), 32'(e.b));
                    chk("busy", 32'(busy), 32'(|e.en));
                end
            end
            if (started) begin
                chk("gnt_eq", 32'(gnt), 32'(drv_en));
                chk("onehot0", 32'($onehot0(drv_en)), 32'd1);
                chk("busy_or", 32'(busy), 32'(|drv_en));
                chk("beat_lt_max", 32'(beat < 3'(MB)), 32'd1);
                if (prev_en != 0 && drv_en != 0)
                    chk("turnaround", 32'(drv_en), 32'(prev_en));
                if (drv_en != 0)
                    chk("owner_match", 32'(drv_en), 32'(4'b0001 << owner));
                if (rst) begin
                    for (int i = 0; i < N; i++) wt[i] = 0;
                end else begin
                    if (drv_en != 0 && prev_en == 0) begin
                        for (int i = 0; i < N; i++) begin
                            if (drv_en[i]) begin
                                wt[i] = 0;
                            end else if (req[i]) begin
                                wt[i]++;
                                chk("fairness", 32'(wt[i] <= N - 1), 32'd1);
                            end
                        end
                    end
                    for (int i = 0; i < N; i++)
                        if (!req[i]) wt[i] = 0;
                end
                prev_en = drv_en;
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic [3:0] ls;
        int         own[4];
        own = '{3, 0, 1, 3};

        // Reset held with all requesting, then first grant.
        step(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // Single burst ended by last on beat 1 (pointer now 1).
        step(0, 4'b0100, 4'b0000, 4'b0100, 2, 0);
        step(0, 4'b0100, 4'b0000, 4'b0100, 2, 1);
        step(0, 4'b0100, 4'b0100, 4'b0000, 2, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 2, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 2, 1);

        // Max-length cutoff, twice back to back.
        repeat (2) begin
            for (int b = 0; b < MB; b++)
                step(0, 4'b0010, 4'b0000, 4'b0010, 1, b);
            step(0, 4'b0010, 4'b0000, 4'b0000, 1, 3);
        end
        step(0, 4'b0000, 4'b0000, 4'b0000, 1, 3);

        // Round robin with wrap, agent 2 skipped (pointer 2).
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < MB; b++)
                step(0, 4'b1011, 4'b0000, 4'(4'b0001 << own[k]), own[k], b);
            step(0, 4'b1011, 4'b0000, 4'b0000, own[k], 3);
        end

        // Owner 3 drops its request on beat 1.
        step(0, 4'b1000, 4'b0000, 4'b1000, 3, 0);
        step(0, 4'b1000, 4'b0000, 4'b1000, 3, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 3, 1);
        step(0, 4'b0000, 4'b0000, 4'b0000, 3, 1);

        // Move pointer to 2, then reset in the middle of a burst.
        step(0, 4'b0010, 4'b0010, 4'b0010, 1, 0);
        step(0, 4'b0010, 4'b0010, 4'b0000, 1, 0);
        step(0, 4'b0101, 4'b0000, 4'b0100, 2, 0);
        step(0, 4'b0101, 4'b0000, 4'b0100, 2, 1);
        step(0, 4'b0101, 4'b0000, 4'b0100, 2, 2);
        step(1, 4'b0101, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0101, 4'b0000, 4'b0001, 0, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        // Randomized requests with persistence; invariants only.
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) rq[i] = ~rq[i];
            ls = '0;
            for (int i = 0; i < N; i++)
                ls[i] = ($urandom_range(3) == 0);
            step(0, rq, ls, 4'b0000, 0, 0, 1'b0);
        end
        step(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
